// File: rtl/nmr_adc_packer.sv
// Packs pairs of 16-bit ADC samples into 32-bit words and buffers them in a 16-deep FWFT FIFO.
// Latency: word visible one edge after its second sample (or flush); OUT_READY low fills the FIFO, then words drop and OVERFLOW sticks.
module nmr_adc_packer #(
    parameter int ADC_DATA_WIDTH = 16,
    parameter int DATABUS_WIDTH  = 32,
    parameter int FIFO_AW        = 4
) (
    input  logic                      ADC_CLK,
    input  logic                      RESET_N,
    input  logic                      CLEAR,
    input  logic [ADC_DATA_WIDTH-1:0] ADC_IN_DATA,
    input  logic                      ADC_IN_VALID,
    input  logic                      ACQ_WND,
    output logic [DATABUS_WIDTH-1:0]  OUT_DATA,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [FIFO_AW:0]          FIFO_LEVEL,
    output logic [DATABUS_WIDTH-1:0]  WORD_COUNT,
    output logic                      OVERFLOW,
    output logic                      BUSY
);

    localparam int                 DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   LVL_ONE  = 1;
    localparam int                 PAD_W    = DATABUS_WIDTH - ADC_DATA_WIDTH;

    typedef enum logic {S_EMPTY, S_HALF} state_t;

    state_t                    state_q, state_d;
    logic [ADC_DATA_WIDTH-1:0] half_q, half_d;
    logic                      acq_q;
    logic [DATABUS_WIDTH-1:0]  mem_q [DEPTH];
    logic [FIFO_AW-1:0]        wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [FIFO_AW:0]          level_q;
    logic [DATABUS_WIDTH-1:0]  out_q, out_d;
    logic [DATABUS_WIDTH-1:0]  wcnt_q;
    logic                      ovf_q;

    logic                      wnd_fall;
    logic                      push_req;
    logic [DATABUS_WIDTH-1:0]  push_dat;
    logic                      full, pop, push_ok, drop;

    assign wnd_fall = acq_q & ~ACQ_WND;

    // A flush only matters when a half word is pending or a lone sample coincides with the window end.
    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        push_req = 1'b0;
        push_dat = '0;
        case (state_q)
            S_EMPTY: begin
                if (ADC_IN_VALID) begin
                    if (wnd_fall) begin
                        push_req = 1'b1;
                        push_dat = {{PAD_W{1'b0}}, ADC_IN_DATA};
                    end else begin
                        half_d  = ADC_IN_DATA;
                        state_d = S_HALF;
                    end
                end
            end
            S_HALF: begin
                if (ADC_IN_VALID) begin
                    push_req = 1'b1;
                    push_dat = {ADC_IN_DATA, half_q};
                    state_d  = S_EMPTY;
                end else if (wnd_fall) begin
                    push_req = 1'b1;
                    push_dat = {{PAD_W{1'b0}}, half_q};
                    state_d  = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    assign full    = (level_q == LVL_FULL);
    assign pop     = ~CLEAR & (level_q != '0) & OUT_READY;
    assign push_ok = ~CLEAR & push_req & (~full | pop);
    assign drop    = ~CLEAR & push_req & full & ~pop;
    assign rd_nxt  = rd_ptr_q + 1'b1;

    // Registered head: preload the word that will sit at the read pointer after this edge.
    always_comb begin
        out_d = out_q;
        if (pop && (level_q > LVL_ONE))
            out_d = mem_q[rd_nxt];
        else if (push_ok && ((level_q == '0) || ((level_q == LVL_ONE) && pop)))
            out_d = push_dat;
    end

    always_ff @(posedge ADC_CLK) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= push_dat;
    end

    always_ff @(posedge ADC_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_EMPTY;
            half_q   <= '0;
            acq_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            out_q    <= '0;
            wcnt_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            acq_q <= ACQ_WND;
            if (CLEAR) begin
                state_q  <= S_EMPTY;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
                wcnt_q   <= '0;
                ovf_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                half_q  <= half_d;
                out_q   <= out_d;
                if (push_ok) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    wcnt_q   <= wcnt_q + 1'b1;
                end
                if (pop)
                    rd_ptr_q <= rd_nxt;
                if (push_ok && !pop)
                    level_q <= level_q + 1'b1;
                else if (pop && !push_ok)
                    level_q <= level_q - 1'b1;
                if (drop)
                    ovf_q <= 1'b1;
            end
        end
    end

    assign OUT_DATA   = out_q;
    assign OUT_VALID  = (level_q != '0);
    assign FIFO_LEVEL = level_q;
    assign WORD_COUNT = wcnt_q;
    assign OVERFLOW   = ovf_q;
    assign BUSY       = (state_q == S_HALF) | (level_q != '0);

endmodule
